// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer for the MIPS IF stage: next-PC selection,
// hazard stalls, debug-unit run/step modes, halt detection and a cycle counter.
module pc_fetch_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_jump_target,
  input  logic                  i_halt_detected,
  input  logic [DATA_WIDTH-1:0] i_pc_incr,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_pc_advance,
  output logic                  o_running,
  output logic                  o_halted,
  output logic [DATA_WIDTH-1:0] o_cycle_count
);

  localparam logic [DATA_WIDTH-1:0] LAST_PC = DATA_WIDTH'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] pc_nxt;
  logic                  active;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = o_pc;
    o_pc_advance = 1'b0;
    active       = 1'b0;

    // A mode switch consumes its cycle; only a settled mode executes.
    unique case (state)
      ST_IDLE:   if (i_enable) state_nxt = i_mode ? ST_STEP : ST_RUN;
      ST_RUN:    if (i_mode) state_nxt = ST_STEP; else active = 1'b1;
      ST_STEP:   if (!i_mode) state_nxt = ST_RUN; else active = i_step;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase

    if (active && !i_reset) begin
      if (i_stall) begin
        pc_nxt = o_pc;
      end else if (i_branch_taken) begin
        pc_nxt       = i_branch_target;
        o_pc_advance = 1'b1;
      end else if (i_jump) begin
        pc_nxt       = i_jump_target;
        o_pc_advance = 1'b1;
      end else if (i_halt_detected || (o_pc == LAST_PC)) begin
        state_nxt = ST_HALTED;
      end else begin
        pc_nxt       = i_pc_incr;
        o_pc_advance = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      o_pc          <= '0;
      o_cycle_count <= '0;
    end else begin
      state <= state_nxt;
      o_pc  <= pc_nxt;
      if (active) o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

  assign o_running = (state == ST_RUN) || (state == ST_STEP);
  assign o_halted  = (state == ST_HALTED);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table from the fetch-control rules,
// then randomized stimulus against a flag-based behavioural model.
module tb_pc_fetch_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst, en, mode, step, stall, br, jmp, halt;
  logic [DW-1:0] brt, jt, pc_incr, pc, cnt;
  logic          adv, running, halted;

  always #5 clk = ~clk;

  // Models the external PC incrementer.
  assign pc_incr = pc + 1;

  pc_fetch_ctrl #(.DATA_WIDTH(DW), .IMEM_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_mode(mode), .i_step(step),
    .i_stall(stall), .i_branch_taken(br), .i_branch_target(brt),
    .i_jump(jmp), .i_jump_target(jt), .i_halt_detected(halt),
    .i_pc_incr(pc_incr), .o_pc(pc), .o_pc_advance(adv),
    .o_running(running), .o_halted(halted), .o_cycle_count(cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst, en, mode, step, stall, br;
    logic [DW-1:0] brt;
    logic          jmp;
    logic [DW-1:0] jt;
    logic          halt;
    logic          adv;
    logic [DW-1:0] pc, cnt;
    logic          run, hlt;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic m, logic s, logic st,
                              logic b, logic [DW-1:0] bt, logic j, logic [DW-1:0] jtg,
                              logic h, logic a, logic [DW-1:0] p, logic [DW-1:0] c,
                              logic rn, logic hl);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.step = s; v.stall = st; v.br = b; v.brt = bt;
    v.jmp = j; v.jt = jtg; v.halt = h; v.adv = a; v.pc = p; v.cnt = c; v.run = rn; v.hlt = hl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; en = v.en; mode = v.mode; step = v.step; stall = v.stall;
    br = v.br; brt = v.brt; jmp = v.jmp; jt = v.jt; halt = v.halt;
  endtask

  // One cycle: inputs at negedge, advance checked before the edge, state after it.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1 check({tag, ".adv"}, DW'(adv), DW'(v.adv));
    @(posedge clk);
    #1;
    check({tag, ".pc"}, pc, v.pc);
    check({tag, ".cnt"}, cnt, v.cnt);
    check({tag, ".run"}, DW'(running), DW'(v.run));
    check({tag, ".hlt"}, DW'(halted), DW'(v.hlt));
  endtask

  vec_t tbl[$];

  // Behavioural reference: running/single-step/halted flags plus PC and count.
  bit            m_on, m_single, m_halted, e_adv;
  logic [DW-1:0] m_pc, m_cnt;

  task automatic model_step();
    e_adv = 1'b0;
    if (rst) begin
      m_pc = '0; m_cnt = '0; m_on = 1'b0; m_single = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      e_adv = 1'b0;
    end else if (!m_on) begin
      if (en) begin m_on = 1'b1; m_single = mode; end
    end else if (mode != m_single) begin
      m_single = mode;
    end else if (!m_single || step) begin
      m_cnt = m_cnt + 1;
      if (stall) e_adv = 1'b0;
      else if (br)  begin m_pc = brt; e_adv = 1'b1; end
      else if (jmp) begin m_pc = jt;  e_adv = 1'b1; end
      else if (halt || m_pc == DW'(DEPTH - 1)) begin m_halted = 1'b1; m_on = 1'b0; end
      else begin m_pc = m_pc + 1; e_adv = 1'b1; end
    end
  endtask

  initial begin
    drive(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));

    //                r e m s st b brt  j jt   h  adv pc    cnt run hlt
    // Continuous run from reset, then stall, branch, redirect priority.
    tbl.push_back(mk(1,1,0,0,0, 0,0,   0,0,   0, 0, 0,    0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,   0,0,   0, 0, 0,    0, 1,0));
    for (int i = 1; i <= 7; i++)
      tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0, 0, 1, DW'(i), DW'(i), 1,0));
    tbl.push_back(mk(0,1,0,0,1, 0,0,   0,0,   0, 0, 7,    8, 1,0));
    tbl.push_back(mk(0,1,0,0,1, 0,0,   0,0,   0, 0, 7,    9, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 1,'h20,0,0,   0, 1, 'h20, 10,1,0));
    tbl.push_back(mk(0,1,0,0,0, 1,'h10,1,'h40,0, 1, 'h10, 11,1,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,   1,'h40,1, 1, 'h40, 12,1,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,   0,0,   1, 0, 'h40, 13,0,1));
    tbl.push_back(mk(0,1,1,1,0, 1,5,   0,0,   0, 0, 'h40, 13,0,1));
    // Mid-run reset with enable held; out-of-range target keeps running.
    tbl.push_back(mk(1,1,0,0,0, 0,0,   0,0,   0, 0, 0,    0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,   0,0,   0, 0, 0,    0, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,   1,12,  0, 1, 12,   1, 1,0));
    tbl.push_back(mk(1,1,0,0,0, 0,0,   0,0,   0, 0, 0,    0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,   0,0,   0, 0, 0,    0, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,   1,300, 0, 1, 300,  1, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,   0,0,   0, 1, 301,  2, 1,0));
    // Single-step mode: step ignored in IDLE, idle steps, step with stall.
    tbl.push_back(mk(1,0,0,0,0, 0,0,   0,0,   0, 0, 0,    0, 0,0));
    tbl.push_back(mk(0,0,1,1,0, 0,0,   0,0,   0, 0, 0,    0, 0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,0,   0,0,   0, 0, 0,    0, 1,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,1,0,0, 0,0, 0,0, 0, 0, 0, 0, 1,0));
    tbl.push_back(mk(0,0,1,1,0, 0,0,   0,0,   0, 1, 1,    1, 1,0));
    tbl.push_back(mk(0,0,1,1,1, 0,0,   0,0,   0, 0, 1,    2, 1,0));
    // Back to RUN, end-of-memory halt, then halted is terminal.
    tbl.push_back(mk(0,0,0,1,0, 0,0,   1,7,   0, 0, 1,    2, 1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,   1,254, 0, 1, 254,  3, 1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,   0,0,   0, 1, 255,  4, 1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,   0,0,   0, 0, 255,  5, 0,1));
    tbl.push_back(mk(0,1,1,1,0, 0,0,   0,0,   0, 0, 255,  5, 0,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,   1,3,   0, 0, 255,  5, 0,1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Hand sequence: counter wraps through a long stalled run is impractical,
    // so exercise mode toggling mid-run: each switch cycle is not active.
    apply(mk(1,1,0,0,0, 0,0, 0,0, 0, 0, 0, 0, 0,0), "seq.rst");
    apply(mk(0,1,0,0,0, 0,0, 0,0, 0, 0, 0, 0, 1,0), "seq.go");
    apply(mk(0,0,1,1,0, 0,0, 0,0, 0, 0, 0, 0, 1,0), "seq.to_step");
    apply(mk(0,0,1,1,0, 0,0, 0,0, 0, 1, 1, 1, 1,0), "seq.step");
    apply(mk(0,0,0,0,0, 0,0, 0,0, 0, 0, 1, 1, 1,0), "seq.to_run");
    apply(mk(0,0,0,0,0, 0,0, 0,0, 0, 1, 2, 2, 1,0), "seq.run");

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst   = (i == 0) || ($urandom_range(0, 40) == 0);
      en    = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      step  = $urandom_range(0, 2) == 0;
      stall = $urandom_range(0, 4) == 0;
      br    = $urandom_range(0, 7) == 0;
      jmp   = $urandom_range(0, 7) == 0;
      halt  = $urandom_range(0, 29) == 0;
      brt   = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(240, 260)) : DW'($urandom_range(0, DEPTH - 1));
      jt    = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(248, 256)) : DW'($urandom_range(0, DEPTH - 1));
      model_step();
      #1 check($sformatf("rnd%0d.adv", i), DW'(adv), DW'(e_adv));
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d.pc", i), pc, m_pc);
      check($sformatf("rnd%0d.cnt", i), cnt, m_cnt);
      check($sformatf("rnd%0d.run", i), DW'(running), DW'(m_on));
      check($sformatf("rnd%0d.hlt", i), DW'(halted), DW'(m_halted));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
